// File: rtl/ram_sync_dp.sv
// Synchronous single-write-port RAM shared by a CPU port, a handshaked loader port
// and a hardware clear sweep; registered write-first read with a valid pulse.
module ram_sync_dp #(
   parameter int               DATA_W    = 8,
   parameter int               ADDR_W    = 4,
   parameter int               DEPTH     = (1 << ADDR_W),
   parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_re,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_stall,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic              ld_req,
   output logic              ld_ack,
   input  logic              clr_start,
   output logic              busy
);

   localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

   state_t            r_state, w_state_next;
   logic [ADDR_W-1:0] r_cnt, w_cnt_next;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;
   logic              r_ld_ack;

   logic              w_idle;
   logic              w_cpu_in_range, w_ld_in_range;
   logic              w_cpu_wr, w_ld_commit, w_ld_wr;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rd_data;

   assign w_idle         = (r_state == S_IDLE);
   assign w_cpu_in_range = ({1'b0, cpu_addr} < DEPTH_W);
   assign w_ld_in_range  = ({1'b0, ld_addr} < DEPTH_W);

   // The loader is held off in its ack cycle (one word per two cycles) and on the
   // cycle a sweep is launched, so its ack never lands inside the sweep.
   assign w_cpu_wr    = w_idle & cpu_we & w_cpu_in_range;
   assign w_ld_commit = w_idle & ld_req & ~cpu_we & ~r_ld_ack & ~clr_start;
   assign w_ld_wr     = w_ld_commit & w_ld_in_range;

   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_cnt;
      w_wdata = CLEAR_VAL;
      if (!w_idle) begin
         w_we = 1'b1;
      end else if (w_cpu_wr) begin
         w_we    = 1'b1;
         w_waddr = cpu_addr;
         w_wdata = cpu_wdata;
      end else if (w_ld_wr) begin
         w_we    = 1'b1;
         w_waddr = ld_addr;
         w_wdata = ld_wdata;
      end
   end

   // Write-first: a read hitting this cycle's write address sees the new word.
   always_comb begin
      w_rd_data = '0;
      if (w_cpu_in_range) begin
         if (w_we && (w_waddr == cpu_addr)) w_rd_data = w_wdata;
         else                               w_rd_data = r_mem[cpu_addr];
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (clr_start) begin
               w_state_next = S_CLEAR;
               w_cnt_next   = '0;
            end
         end
         S_CLEAR: begin
            if (r_cnt == LAST_ADDR) begin
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_ld_ack <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_rvalid <= w_idle & cpu_re;
         r_ld_ack <= w_ld_commit;
         if (w_idle && cpu_re) r_rdata <= w_rd_data;
      end
   end

   assign cpu_rdata  = r_rdata;
   assign cpu_rvalid = r_rvalid;
   assign ld_ack     = r_ld_ack;
   assign busy       = ~w_idle;
   assign cpu_stall  = ~w_idle;

endmodule

// File: tb/tb_ram_sync_dp.sv
// Bench for ram_sync_dp: a transaction-level memory model checked every cycle on a
// full-depth instance, plus directed literal checks on it and on a DEPTH=12 instance.
module tb_ram_sync_dp;

   localparam int D = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic [3:0] a_cpu_addr = '0, a_ld_addr = '0;
   logic [7:0] a_cpu_wdata = '0, a_ld_wdata = '0, a_cpu_rdata;
   logic       a_cpu_we = 0, a_cpu_re = 0, a_ld_req = 0, a_clr_start = 0;
   logic       a_cpu_rvalid, a_cpu_stall, a_ld_ack, a_busy;

   logic [3:0] b_cpu_addr = '0, b_ld_addr = '0;
   logic [7:0] b_cpu_wdata = '0, b_ld_wdata = '0, b_cpu_rdata;
   logic       b_cpu_we = 0, b_cpu_re = 0, b_ld_req = 0;
   logic       b_cpu_rvalid, b_cpu_stall, b_ld_ack, b_busy;

   int n_cmp = 0;
   int n_bad = 0;

   ram_sync_dp #(.DATA_W(8), .ADDR_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata), .cpu_we(a_cpu_we), .cpu_re(a_cpu_re),
      .cpu_rdata(a_cpu_rdata), .cpu_rvalid(a_cpu_rvalid), .cpu_stall(a_cpu_stall),
      .ld_addr(a_ld_addr), .ld_wdata(a_ld_wdata), .ld_req(a_ld_req), .ld_ack(a_ld_ack),
      .clr_start(a_clr_start), .busy(a_busy)
   );

   ram_sync_dp #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata), .cpu_we(b_cpu_we), .cpu_re(b_cpu_re),
      .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid), .cpu_stall(b_cpu_stall),
      .ld_addr(b_ld_addr), .ld_wdata(b_ld_wdata), .ld_req(b_ld_req), .ld_ack(b_ld_ack),
      .clr_start(1'b0), .busy(b_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- model of the full-depth instance ----------------
   logic [7:0] m_mem   [D];
   bit         m_known [D];
   logic [7:0] m_rdata = '0;
   bit         m_rdata_known = 1;
   bit         m_rvalid = 0, m_ack = 0;
   int         m_clear_left = 0;

   initial begin
      for (int i = 0; i < D; i++) begin
         m_mem[i]   = '0;
         m_known[i] = 0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_rdata = '0; m_rdata_known = 1; m_rvalid = 0; m_ack = 0; m_clear_left = 0;
         end else if (m_clear_left > 0) begin
            m_mem[D - m_clear_left]   = 8'h00;
            m_known[D - m_clear_left] = 1;
            m_clear_left--;
            m_rvalid = 0;
            m_ack    = 0;
         end else begin
            bit commit;
            commit = a_ld_req && !a_cpu_we && !m_ack && !a_clr_start;
            if (a_cpu_we) begin
               m_mem[a_cpu_addr] = a_cpu_wdata; m_known[a_cpu_addr] = 1;
            end else if (commit) begin
               m_mem[a_ld_addr] = a_ld_wdata; m_known[a_ld_addr] = 1;
            end
            m_ack    = commit;
            m_rvalid = a_cpu_re;
            if (a_cpu_re) begin
               m_rdata       = m_mem[a_cpu_addr];
               m_rdata_known = m_known[a_cpu_addr];
            end
            if (a_clr_start) m_clear_left = D;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("model_rvalid", a_cpu_rvalid, m_rvalid);
            check("model_ack",    a_ld_ack,     m_ack);
            check("model_busy",   a_busy,       m_clear_left > 0);
            check("model_stall",  a_cpu_stall,  m_clear_left > 0);
            if (m_rdata_known) check("model_rdata", a_cpu_rdata, m_rdata);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_wr(input logic [3:0] addr, input logic [7:0] data);
      a_cpu_we = 1; a_cpu_addr = addr; a_cpu_wdata = data;
      step();
      a_cpu_we = 0;
   endtask

   task automatic a_rd(input string name, input logic [3:0] addr, input logic [7:0] exp);
      a_cpu_re = 1; a_cpu_addr = addr;
      step();
      a_cpu_re = 0;
      $display("read A addr=%0d data=0x%02h", addr, a_cpu_rdata);
      check(name, a_cpu_rdata, exp);
      check({name, "_rvalid"}, a_cpu_rvalid, 1);
   endtask

   task automatic b_wr(input logic [3:0] addr, input logic [7:0] data);
      b_cpu_we = 1; b_cpu_addr = addr; b_cpu_wdata = data;
      step();
      b_cpu_we = 0;
   endtask

   task automatic b_rd(input string name, input logic [3:0] addr, input logic [7:0] exp);
      b_cpu_re = 1; b_cpu_addr = addr;
      step();
      b_cpu_re = 0;
      $display("read B addr=%0d data=0x%02h", addr, b_cpu_rdata);
      check(name, b_cpu_rdata, exp);
      check({name, "_rvalid"}, b_cpu_rvalid, 1);
   endtask

   initial begin
      int n;
      #1;
      check("rst_rdata",  a_cpu_rdata,  0);
      check("rst_rvalid", a_cpu_rvalid, 0);
      check("rst_stall",  a_cpu_stall,  0);
      check("rst_ack",    a_ld_ack,     0);
      check("rst_busy",   a_busy,       0);
      step(); step();
      rst_n = 1;
      step();

      // write then read back, latency 1
      a_wr(4'd3, 8'hA5);
      a_rd("t1_read", 4'd3, 8'hA5);
      step();
      check("t1_rvalid_pulse", a_cpu_rvalid, 0);

      // read-during-write returns the new data
      a_cpu_we = 1; a_cpu_re = 1; a_cpu_addr = 4'd7; a_cpu_wdata = 8'h3C;
      step();
      a_cpu_we = 0; a_cpu_re = 0;
      check("t2_wfirst", a_cpu_rdata, 8'h3C);

      // loader blocked by CPU writes, commits once they stop
      a_ld_req = 1; a_ld_addr = 4'd2; a_ld_wdata = 8'h11;
      a_cpu_we = 1; a_cpu_addr = 4'd9; a_cpu_wdata = 8'h55;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3_no_ack", a_ld_ack, 0);
      end
      a_cpu_we = 0;
      step();
      check("t3_ack", a_ld_ack, 1);
      a_ld_req = 0;
      step();
      check("t3_ack_pulse", a_ld_ack, 0);
      a_rd("t3_mem2", 4'd2, 8'h11);
      a_rd("t3_mem9", 4'd9, 8'h55);

      // back-to-back loader words: one per two cycles
      a_ld_req = 1; a_ld_addr = 4'd4; a_ld_wdata = 8'h44;
      step();
      check("t3b_ack1", a_ld_ack, 1);
      a_ld_addr = 4'd5; a_ld_wdata = 8'h45;
      step();
      check("t3b_gap", a_ld_ack, 0);
      step();
      check("t3b_ack2", a_ld_ack, 1);
      a_ld_req = 0;
      step();
      a_rd("t3b_mem4", 4'd4, 8'h44);
      a_rd("t3b_mem5", 4'd5, 8'h45);

      // full clear sweep with CPU read and loader request held during it
      for (int i = 0; i < D; i++) a_wr(4'(i), 8'(i * 17 + 1));
      a_clr_start = 1;
      step();
      a_clr_start = 0;
      a_cpu_re = 1; a_cpu_addr = 4'd0;
      a_ld_req = 1; a_ld_addr = 4'd6; a_ld_wdata = 8'h77;
      check("t4_busy", a_busy, 1);
      check("t4_rvalid_blocked", a_cpu_rvalid, 0);
      n = 1;
      while (a_busy && n < 40) begin
         step();
         if (a_busy) begin
            n++;
            check("t4_rvalid_in_clear", a_cpu_rvalid, 0);
            check("t4_ack_in_clear", a_ld_ack, 0);
         end
      end
      check("t4_busy_cycles", n, 16);
      a_cpu_re = 0;
      for (int k = 0; k < 10 && !a_ld_ack; k++) step();
      check("t4_ld_after_clear", a_ld_ack, 1);
      a_ld_req = 0;
      step();
      for (int i = 0; i < D; i++) a_rd("t4_cleared", 4'(i), (i == 6) ? 8'h77 : 8'h00);

      // reset in the middle of a sweep
      for (int i = 0; i < D; i++) a_wr(4'(i), 8'(8'h40 + i));
      a_clr_start = 1;
      step();
      a_clr_start = 0;
      for (int i = 0; i < 5; i++) step();
      check("t5_busy_before", a_busy, 1);
      rst_n = 0;
      #1;
      check("t5_busy_abort", a_busy, 0);
      check("t5_stall_abort", a_cpu_stall, 0);
      check("t5_rdata_rst", a_cpu_rdata, 0);
      step(); step();
      rst_n = 1;
      step();
      for (int i = 0; i < D; i++) a_rd("t5_partial", 4'(i), (i < 5) ? 8'h00 : 8'(8'h40 + i));

      // DEPTH=12 instance: out-of-range accesses
      for (int i = 0; i < 12; i++) b_wr(4'(i), 8'(8'hB0 + i));
      b_wr(4'd13, 8'hFF);
      b_rd("t6_mem0", 4'd0, 8'hB0);
      b_rd("t6_oor_read", 4'd13, 8'h00);
      b_ld_req = 1; b_ld_addr = 4'd14; b_ld_wdata = 8'hEE;
      step();
      check("t6_oor_ld_ack", b_ld_ack, 1);
      b_ld_req = 0;
      step();
      for (int i = 0; i < 12; i++) b_rd("t6_intact", 4'(i), 8'(8'hB0 + i));

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
